// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers (if/id, id/ex, ex/mem, mem/wb):
// state encoding, default widths and the state-to-occupancy mapping.
package pipe_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CTRL_W = 16;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffered pipeline entry (control + data) with load enable and async clear.
// Clearing zeroes only the control field so the data keeps its last value.
module pipe_entry_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_clear) begin
      r_ctrl <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with flush and a saturating
// stall-cycle counter. in_ready is registered, so out_ready never reaches it combinationally.
module pipeline_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  pipe_state_e       r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [1:0]        r_occupancy;
  logic [CNT_W-1:0]  r_stall_count;

  pipe_state_e       w_state_next;
  logic              w_accept;
  logic              w_consume;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data_d;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = r_out_valid & out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_ONE;
            w_main_load  = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_consume) begin
            w_state_next = ST_FULL;
            w_skid_load  = 1'b1;
          end else if (!w_accept && w_consume) begin
            w_state_next = ST_EMPTY;
            w_main_clear = 1'b1;
          end else if (w_accept && w_consume) begin
            w_main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_consume) begin
            w_state_next     = ST_ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  assign w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_d = w_main_from_skid ? w_skid_data : in_data;

  // Handshake flags are registered from the next state so they line up with the buffer contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != ST_FULL);
      r_out_valid <= (w_state_next != ST_EMPTY);
      r_occupancy <= state_occupancy(w_state_next);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_load    (w_main_load),
    .i_clear   (w_main_clear),
    .i_ctrl    (w_main_ctrl_d),
    .i_data    (w_main_data_d),
    .o_ctrl    (w_main_ctrl),
    .o_data    (w_main_data)
  );

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_load    (w_skid_load),
    .i_clear   (w_skid_clear),
    .i_ctrl    (in_ctrl),
    .i_data    (in_data),
    .o_ctrl    (w_skid_ctrl),
    .o_data    (w_skid_data)
  );

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_ctrl    = w_main_ctrl;
  assign out_data    = w_main_data;
  assign occupancy   = r_occupancy;
  assign stall_count = r_stall_count;

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, the width of the payload data field (PC, operands, instruction word).
REQ-002 The module SHALL have parameter CTRL_W, default 16, the width of the control field; the control field is forced to zero for a bubble.
REQ-003 The module SHALL have parameter CNT_W, default 16, the width of the stall-cycle counter.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the upstream stage offers an entry.
REQ-007 The module SHALL have port in_ready, output, 1 bit: this stage accepts the entry this cycle.
REQ-008 The module SHALL have port in_ctrl, input, CTRL_W bits, and port in_data, input, DATA_W bits: the offered control and data.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the downstream stage consumes the head entry.
REQ-011 The module SHALL have port out_ctrl, output, CTRL_W bits, and port out_data, output, DATA_W bits: the head entry.
REQ-012 The module SHALL have port flush, input, 1 bit: discard all held entries (branch taken, hazard).
REQ-013 The module SHALL have port occupancy, output, 2 bits: the number of held entries (0..2).
REQ-014 The module SHALL have port stall_count, output, CNT_W bits: a saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Storage SHALL be a 2-entry buffer: a main register drives the outputs and a skid register absorbs one entry when downstream stalls.
REQ-016 The state machine SHALL have states EMPTY, ONE and FULL; occupancy SHALL be 0, 1 or 2 respectively.
REQ-017 in_ready SHALL be registered, equal to (state != FULL), with no combinational path from out_ready.
REQ-018 An entry is accepted when in_valid and in_ready are both 1. An entry is consumed when out_valid and out_ready are both 1.
REQ-019 EMPTY: on accept, go to ONE and load main.
REQ-020 ONE: accept without consume goes to FULL and loads skid. Consume without accept goes to EMPTY. Accept and consume together stays ONE and reloads main.
REQ-021 FULL: on consume, skid moves to main and the state goes to ONE; no accept is possible in FULL.
REQ-022 Latency SHALL be 1 cycle from accept into EMPTY to out_valid=1. Throughput SHALL be 1 entry per cycle while out_ready=1.
REQ-023 Entries SHALL leave in acceptance order; no entry is duplicated or dropped except by flush.
REQ-024 When out_valid=0, out_ctrl SHALL be zero; out_data is don't-care but SHALL hold its last value.
REQ-025 flush=1 SHALL, at the next edge, force state EMPTY, out_valid=0, out_ctrl=0 and in_ready=1. An accept or consume in the same cycle is discarded; flush has priority over all events.
REQ-026 stall_count SHALL increment by 1 per stalled cycle, saturate at 2^CNT_W-1 and never wrap, and not change on flush; it is cleared only by reset.
REQ-027 While held with out_ready=0, out_ctrl and out_data SHALL remain stable.

Reset
REQ-028 On reset=0, asynchronously: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_count=0, in_ready=1, skid contents zero.
REQ-029 Reset asserted mid-transfer SHALL discard both entries. The first accept is possible at the first rising edge after reset=1.

Structure
REQ-030 State encoding (EMPTY/ONE/FULL) and the default widths SHALL live in the shared package pipe_pkg, reused by all stage registers (if/id, id/ex, ex/mem, mem/wb).
REQ-031 The module SHALL be a single flat module; the per-entry register (ctrl+data with load enable and async clear) is the one natural sub-module, pipe_entry_reg, instantiated twice.

Verification
REQ-032 After reset, in_valid=1 with data 0x0001..0x0004 on consecutive cycles and out_ready=1 -> out_data 0x0001..0x0004 one cycle later each, occupancy 1, stall_count 0.
REQ-033 With out_ready=0, push 0x00A1, 0x00A2, 0x00A3 -> occupancy 2, in_ready=0 after the second accept, 0x00A3 held upstream; out_ready=1 -> outputs in order 0x00A1, 0x00A2, 0x00A3.
REQ-034 In FULL, flush=1 together with out_ready=1 -> next cycle out_valid=0, out_ctrl=0, occupancy 0, in_ready=1, and no entry emerges.
REQ-035 CNT_W=4, out_valid=1, out_ready=0 held for 20 cycles -> stall_count reaches 15 and stays 15.
REQ-036 reset=0 pulsed between clock edges while in FULL -> outputs zero immediately without a clock edge; after release, 0x0055 flows through with 1-cycle latency.
